// File: rtl/vga_motion_pkg.sv
// Shared types and geometry helpers for the frame-synchronous ball motion scheduler.
package vga_motion_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int RADIUS_DEF   = 100;

    // Frame tick fires at hpos==TICK_HPOS on the first blanking line (vpos==V_ACTIVE).
    localparam int TICK_HPOS = 0;

    function automatic int axis_min(input int radius);
        return radius;
    endfunction

    function automatic int axis_max(input int active, input int radius);
        return active - 1 - radius;
    endfunction

    function automatic int tick_line(input int v_active);
        return v_active;
    endfunction

    localparam int X_MIN_DEF = axis_min(RADIUS_DEF);
    localparam int X_MAX_DEF = axis_max(H_ACTIVE_DEF, RADIUS_DEF);
    localparam int Y_MIN_DEF = axis_min(RADIUS_DEF);
    localparam int Y_MAX_DEF = axis_max(V_ACTIVE_DEF, RADIUS_DEF);

endpackage

// File: rtl/axis_bounce_step.sv
// One-axis position step with reflection at the [min,max] bounds.
module axis_bounce_step #(
    parameter int W = 10
) (
    input  logic [W-1:0] pos,
    input  logic         dir,
    input  logic [W-1:0] min,
    input  logic [W-1:0] max,
    output logic [W-1:0] next_pos,
    output logic         next_dir,
    output logic         bounce
);

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        bounce   = 1'b0;
        if (dir) begin
            if (pos == max) begin
                next_pos = max - W'(1);
                next_dir = 1'b0;
                bounce   = 1'b1;
            end else begin
                next_pos = pos + W'(1);
            end
        end else begin
            if (pos == min) begin
                next_pos = min + W'(1);
                next_dir = 1'b1;
                bounce   = 1'b1;
            end else begin
                next_pos = pos - W'(1);
            end
        end
    end

endmodule

// File: rtl/ball_motion_scheduler.sv
// Advances the ball only during vertical blanking so the renderer never sees
// coordinates change mid-frame; supports frame divider, pause and single-step.
module ball_motion_scheduler
    import vga_motion_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int RADIUS   = 100,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter int COORD_W  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] hpos,
    input  logic [COORD_W-1:0] vpos,
    input  logic               run,
    input  logic               step_req,
    input  logic [2:0]         speed,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               dir_x,
    output logic               dir_y,
    output logic               bounce_x,
    output logic               bounce_y,
    output logic [7:0]         frame_count,
    output logic               busy
);

    localparam logic [COORD_W-1:0] X_MIN  = COORD_W'(axis_min(RADIUS));
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(axis_max(H_ACTIVE, RADIUS));
    localparam logic [COORD_W-1:0] Y_MIN  = COORD_W'(axis_min(RADIUS));
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(axis_max(V_ACTIVE, RADIUS));
    localparam logic [COORD_W-1:0] TICK_H = COORD_W'(TICK_HPOS);
    localparam logic [COORD_W-1:0] TICK_V = COORD_W'(tick_line(V_ACTIVE));

    state_t               state;
    logic [2:0]           div;
    logic                 step_pending;
    logic [COORD_W-1:0]   shadow_x, shadow_y;
    logic                 shadow_dx, shadow_dy, shadow_bx, shadow_by;
    logic [COORD_W-1:0]   nx, ny;
    logic                 ndx, ndy, nbx, nby;
    logic                 frame_tick;

    assign frame_tick = (hpos == TICK_H) && (vpos == TICK_V);
    assign busy       = (state != IDLE);

    axis_bounce_step #(.W(COORD_W)) u_step_x (
        .pos(ball_x), .dir(dir_x), .min(X_MIN), .max(X_MAX),
        .next_pos(nx), .next_dir(ndx), .bounce(nbx)
    );

    axis_bounce_step #(.W(COORD_W)) u_step_y (
        .pos(ball_y), .dir(dir_y), .min(Y_MIN), .max(Y_MAX),
        .next_pos(ny), .next_dir(ndy), .bounce(nby)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            div          <= 3'd0;
            step_pending <= 1'b0;
            frame_count  <= 8'd0;
            ball_x       <= COORD_W'(X_INIT);
            ball_y       <= COORD_W'(Y_INIT);
            dir_x        <= 1'b1;
            dir_y        <= 1'b1;
            bounce_x     <= 1'b0;
            bounce_y     <= 1'b0;
            shadow_x     <= COORD_W'(X_INIT);
            shadow_y     <= COORD_W'(Y_INIT);
            shadow_dx    <= 1'b1;
            shadow_dy    <= 1'b1;
            shadow_bx    <= 1'b0;
            shadow_by    <= 1'b0;
        end else begin
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            if (step_req)
                step_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        frame_count <= frame_count + 8'd1;
                        if (run) begin
                            // >= lets a speed decrease mid-count fire on the next tick
                            if (div >= speed) begin
                                div   <= 3'd0;
                                state <= CALC_X;
                            end else begin
                                div <= div + 3'd1;
                            end
                        end else if (step_pending) begin
                            step_pending <= step_req;
                            state        <= CALC_X;
                        end
                    end
                end
                CALC_X: begin
                    shadow_x  <= nx;
                    shadow_dx <= ndx;
                    shadow_bx <= nbx;
                    state     <= CALC_Y;
                end
                CALC_Y: begin
                    shadow_y  <= ny;
                    shadow_dy <= ndy;
                    shadow_by <= nby;
                    state     <= COMMIT;
                end
                COMMIT: begin
                    ball_x   <= shadow_x;
                    ball_y   <= shadow_y;
                    dir_x    <= shadow_dx;
                    dir_y    <= shadow_dy;
                    bounce_x <= shadow_bx;
                    bounce_y <= shadow_by;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_scheduler.sv
// Directed checks of the ball motion scheduler: latency, bounces, divider, pause/step, reset abort.
module tb_ball_motion_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hpos, vpos;
    logic       run, step_req;
    logic [2:0] speed;
    logic [9:0] ball_x, ball_y;
    logic       dir_x, dir_y, bounce_x, bounce_y, busy;
    logic [7:0] frame_count;

    int n_cmp = 0;
    int n_bad = 0;

    ball_motion_scheduler dut (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
        .run(run), .step_req(step_req), .speed(speed),
        .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
        .bounce_x(bounce_x), .bounce_y(bounce_y),
        .frame_count(frame_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Tick cycle T, returns sampling inside T+4.
    task automatic tick_frame();
        hpos = 10'd0; vpos = 10'd480;
        cyc(1);
        hpos = 10'd5; vpos = 10'd0;
        cyc(3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step_req = 1'b0; speed = 3'd0;
        hpos = 10'd5; vpos = 10'd0;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        chk("reset_x", ball_x, 320);
        chk("reset_y", ball_y, 240);
        chk("reset_dx", dir_x, 1);
        chk("reset_dy", dir_y, 1);
        chk("reset_fc", frame_count, 0);
        chk("reset_busy", busy, 0);

        // First move with explicit latency checks
        run = 1'b1; speed = 3'd0;
        hpos = 10'd0; vpos = 10'd480;
        cyc(1);
        hpos = 10'd5; vpos = 10'd0;
        chk("busy_t1", busy, 1);
        cyc(1);
        chk("busy_t2", busy, 1);
        cyc(1);
        chk("busy_t3", busy, 1);
        chk("no_early_x", ball_x, 320);
        cyc(1);
        chk("t4_x", ball_x, 321);
        chk("t4_y", ball_y, 241);
        chk("t4_fc", frame_count, 1);
        chk("t4_busy", busy, 0);

        for (int i = 2; i <= 139; i++) tick_frame();
        chk("t139_y", ball_y, 379);
        chk("t139_x", ball_x, 459);
        tick_frame();
        chk("t140_y", ball_y, 378);
        chk("t140_dy", dir_y, 0);
        chk("t140_by", bounce_y, 1);
        chk("t140_bx", bounce_x, 0);
        chk("t140_x", ball_x, 460);
        cyc(1);
        chk("t140_by_drop", bounce_y, 0);

        for (int i = 141; i <= 219; i++) tick_frame();
        chk("t219_x", ball_x, 539);
        chk("t219_y", ball_y, 299);
        tick_frame();
        chk("t220_x", ball_x, 538);
        chk("t220_dx", dir_x, 0);
        chk("t220_bx", bounce_x, 1);
        chk("t220_by", bounce_y, 0);
        chk("t220_y", ball_y, 298);
        chk("t220_fc", frame_count, 220);
        cyc(1);
        chk("t220_bx_drop", bounce_x, 0);

        // Divider: speed=2 moves on ticks 3 and 6
        do_reset();
        speed = 3'd2;
        tick_frame(); tick_frame();
        chk("div_t2_x", ball_x, 320);
        tick_frame();
        chk("div_t3_x", ball_x, 321);
        tick_frame(); tick_frame();
        chk("div_t5_y", ball_y, 241);
        tick_frame();
        chk("div_t6_x", ball_x, 322);
        chk("div_t6_y", ball_y, 242);
        chk("div_t6_fc", frame_count, 6);

        // Pause and single step
        do_reset();
        run = 1'b0; speed = 3'd0;
        for (int i = 0; i < 5; i++) tick_frame();
        chk("pause_x", ball_x, 320);
        chk("pause_y", ball_y, 240);
        chk("pause_fc", frame_count, 5);
        step_req = 1'b1;
        cyc(1);
        step_req = 1'b0;
        tick_frame();
        chk("step_x", ball_x, 321);
        chk("step_y", ball_y, 241);
        tick_frame();
        chk("step_once_x", ball_x, 321);
        chk("step_once_fc", frame_count, 7);

        // Reset landing in CALC_Y aborts the step
        do_reset();
        run = 1'b1;
        tick_frame(); tick_frame(); tick_frame();
        chk("pre_abort_x", ball_x, 323);
        hpos = 10'd0; vpos = 10'd480;
        cyc(1);
        hpos = 10'd5; vpos = 10'd0;
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        chk("abort_x", ball_x, 320);
        chk("abort_y", ball_y, 240);
        chk("abort_dx", dir_x, 1);
        chk("abort_dy", dir_y, 1);
        chk("abort_fc", frame_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_bounce", {bounce_x, bounce_y}, 0);
        rst_n = 1'b1;
        cyc(4);
        chk("abort_no_commit_x", ball_x, 320);
        chk("abort_no_commit_y", ball_y, 240);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
